// File: rtl/iter_alu_pkg.sv
// Shared op encodings, FSM states and helpers for the iterative ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_XOR   = 4'd6,
        OP_MUL   = 4'd8,
        OP_MULHU = 4'd9,
        OP_DIVU  = 4'd10,
        OP_REMU  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per clock.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_lo_o,
    output logic [WIDTH-1:0] product_hi_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend  = lo_q[0] ? opnd_q : '0;
        add_sum = {1'b0, acc_q} + {1'b0, addend};
        shifted = {acc_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};

        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;

        if (start_i) begin
            acc_d    = '0;
            lo_d     = a_i;
            opnd_d   = b_i;
            is_div_d = is_div_i;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (is_div_q) begin
                // A zero divisor never borrows, so quotient fills with ones and the remainder ends up equal to a.
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = add_sum[WIDTH:1];
                lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    // Results come from the next-state values so the final step can be captured on the same edge that completes it.
    assign busy_o       = (cnt_q != '0);
    assign done_o       = (cnt_q == CW'(1));
    assign product_lo_o = lo_d;
    assign product_hi_o = acc_d;
    assign quotient_o   = lo_d;
    assign remainder_o  = acc_d;

endmodule

// File: rtl/iter_alu.sv
// Registered, handshaked ALU with single-cycle logic/arith ops and iterative unsigned mul/div.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             overflow
);

    alu_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi, md_quo, md_rem;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic [WIDTH-1:0] it_res;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (md_start),
        .is_div_i     (is_divide(control)),
        .a_i          (a),
        .b_i          (b),
        .busy_o       (md_busy),
        .done_o       (md_done),
        .product_lo_o (md_lo),
        .product_hi_o (md_hi),
        .quotient_o   (md_quo),
        .remainder_o  (md_rem)
    );

    assign in_ready  = (state_q == IDLE) && !md_busy;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        dif      = {1'b0, a} - {1'b0, b};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (control)
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = dif[WIDTH-1:0];
                sc_carry = dif[WIDTH];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  sc_res = a ^ b;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_MUL:   it_res = md_lo;
            OP_MULHU: it_res = md_hi;
            OP_DIVU:  it_res = md_quo;
            OP_REMU:  it_res = md_rem;
            default:  it_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        out_d    = out_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        md_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d = control;
                    if (is_iterative(control)) begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        out_d   = sc_res;
                        zero_d  = (sc_res == '0);
                        neg_d   = sc_res[WIDTH-1];
                        carry_d = sc_carry;
                        ovf_d   = sc_ovf;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    out_d   = it_res;
                    zero_d  = (it_res == '0);
                    neg_d   = it_res[WIDTH-1];
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed plus randomized bench for iter_alu against an arithmetic reference model.
module tb_iter_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    iter_alu #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic c, output logic v);
        longint unsigned p;
        longint          s;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                p = {32'd0, x} + {32'd0, y};
                r = p[31:0];
                c = p[32];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = x - y;
                c = (x < y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd5: r = (x < y) ? 32'd1 : 32'd0;
            4'd6: r = x ^ y;
            4'd8: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
            4'd9: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
            4'd10: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd11: r = (y == 0) ? x : x % y;
            default: r = '0;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [31:0] er;
        logic        ec;
        logic        ev;
        int          lat;
        int          exp_lat;
        model(op, x, y, er, ec, ev);
        exp_lat = (op >= 4'd8 && op <= 4'd11) ? 33 : 1;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        control  = op;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            check("in_ready_busy", in_ready, 0);
            a       = $urandom;
            b       = $urandom;
            control = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", op), lat, exp_lat);
        check($sformatf("out op%0d a=%0h b=%0h", op, x, y), out, er);
        check($sformatf("zero op%0d", op), zero, (er == 0));
        check($sformatf("neg op%0d", op), neg, er[31]);
        check($sformatf("carry op%0d", op), carry, ec);
        check($sformatf("overflow op%0d", op), overflow, ev);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            control  = 4'd0;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_out", out, er);
            check("hold_flags", {zero, neg, carry, overflow}, {(er == 0), er[31], ec, ev});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        control   = '0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out", out, 0);
        check("reset_flags", {zero, neg, carry, overflow}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_zero", zero, 0);

        run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        check("add_ovf_out", out, 32'h8000_0000);
        run_op(4'd1, 32'h0000_0001, 32'h0000_0002, 0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd10, 32'd100, 32'd7, 0);
        run_op(4'd11, 32'd100, 32'd7, 0);
        run_op(4'd10, 32'h0000_1234, 32'd0, 0);
        run_op(4'd11, 32'h0000_1234, 32'd0, 0);
        run_op(4'd2, 32'hF0F0_1234, 32'h0F0F_1234, 5);
        run_op(4'd11, 32'hDEAD_BEEF, 32'd13, 5);
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd1, 32'h8000_0000, 32'd1, 0);
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd12, 32'h1234_5678, 32'd9, 0);

        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (rop >= 4'd10 && rop <= 4'd11 && $urandom_range(0, 1) == 1) rb = rb >> $urandom_range(8, 28);
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd1000;
        b        = 32'd3;
        control  = 4'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_busy", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_in_ready", in_ready, 1);
        check("mid_reset_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_release_out_valid", out_valid, 0);
        check("mid_release_in_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        check("no_stale_result", out_valid, 0);
        run_op(4'd5, 32'd1, 32'hFFFF_FFFF, 0);
        check("sltu_after_reset", out, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Registered, handshaked ALU. Extends the combinational ALU op set with SLTU, XOR and iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU).
- Parametrised in datapath width.
- Sits between decode/issue and writeback. Multi-cycle ops stall issue through in_ready.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4 and a power of two.
- CW, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- control  in  4  operation select
- out_valid  out  1  result registered and valid
- out_ready  in  1  consumer takes the result
- out  out  WIDTH  result
- zero  out  1  out == 0
- neg  out  1  out[WIDTH-1]
- carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - out, zero, neg, carry, overflow all 0 (zero is registered, so it also reads 0 in reset).
  - Iteration counter and accumulators cleared.
- Control encoding:
  - Single-cycle: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 SLTU, 6 XOR.
  - Iterative: 8 MUL (low WIDTH bits of a*b), 9 MULHU (high WIDTH bits, unsigned), 10 DIVU, 11 REMU.
  - Any other code: single-cycle, out=0.
- Accept rule: an op is accepted on the edge where in_valid && in_ready. in_ready = (state==IDLE).
- States:
  - IDLE -> DONE on accepting a single-cycle op. The result is computed combinationally and registered on the accept edge, so out_valid rises 1 cycle after accept.
  - IDLE -> BUSY on accepting an iterative op. Operands are latched and the counter is loaded with WIDTH.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle, counter decrements. When counter==1 the step completes and the state goes to DONE. out_valid rises exactly WIDTH+1 cycles after accept.
  - DONE: out_valid=1. out and flags are held stable while out_ready=0. On out_ready the state returns to IDLE.
  - No accept happens in the same cycle as a DONE->IDLE handoff, so back-to-back throughput is one op per 2 cycles for single-cycle ops.
- Arithmetic:
  - ADD: {carry,out} = a+b at WIDTH+1 bits.
  - SUB: {carry,out} = {0,a}-{0,b}, so carry=1 iff a<b unsigned.
  - ADD overflow: a,b same sign and out sign differs. SUB overflow: a,b differ in sign and out sign differs from a.
  - MUL/MULHU use the 2*WIDTH-bit unsigned product.
- Divide by zero: DIVU gives all ones; REMU gives a. Still takes WIDTH+1 cycles; no exception.
- Flags are registered together with out; zero and neg are derived from the registered out value.
- Inputs a, b, control are ignored while not accepted. Changes to them during BUSY have no effect.
- Reset mid-operation (rst_n low in BUSY or DONE): immediate return to reset values. The in-flight result is discarded.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum holding the control encodings above.
  - alu_state_e {IDLE, BUSY, DONE}.
  - is_iterative(op) function.
- Sub-module muldiv_iter:
  - Iterative unsigned multiplier/divider with start/busy/done.
  - Parameter WIDTH; outputs product_lo, product_hi, quotient, remainder.
  - iter_alu instantiates it and muxes results in DONE.

Test Plan:
- Reset: rst_n=0 then release -> in_ready=1, out_valid=0, out=0, zero=0 (registered reset value), carry=overflow=0.
- ADD, WIDTH=32: a=0x7FFFFFFF, b=1 -> one cycle later out=0x80000000, overflow=1, neg=1, carry=0. SUB with a=1, b=2 -> out=0xFFFFFFFF, carry=1, overflow=0.
- MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, out=0xFFFFFFFE. MUL with the same operands -> out=0x00000001.
- DIVU/REMU: a=100, b=7 -> 14 and 2. With b=0, a=0x1234 -> DIVU=0xFFFFFFFF, REMU=0x1234. in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out and flags stable, in_ready=0. Release -> IDLE next cycle.
- Async reset asserted mid-DIVU (cycle 10 of BUSY) -> out_valid=0 and in_ready=1 immediately on rst_n release. A subsequent SLTU with a=1, b=0xFFFFFFFF gives out=1.
